// File: rtl/morse_keyer_encoder_if.sv
// Letter/symbol output bundle of the Morse keyer front end.
// master = keyer driving results, slave = lookup/display consumer.
interface morse_keyer_encoder_if #(
    parameter int MAX_SYMS = 6
);
    localparam int LW = 2 * MAX_SYMS;
    localparam int SW = $clog2(MAX_SYMS + 1);

    logic [LW-1:0] letter;
    logic [SW-1:0] sym_count;
    logic          letter_valid;
    logic          letter_err;
    logic [1:0]    dod;
    logic          dod_valid;
    logic          word_gap;

    modport master (
        output letter,
        output sym_count,
        output letter_valid,
        output letter_err,
        output dod,
        output dod_valid,
        output word_gap
    );

    modport slave (
        input letter,
        input sym_count,
        input letter_valid,
        input letter_err,
        input dod,
        input dod_valid,
        input word_gap
    );
endinterface

// File: rtl/morse_keyer_encoder.sv
// Debounced, tick-timed Morse keyer: classifies presses as dot/dash,
// packs them into letters and flags letter/word boundaries on silence.
module morse_keyer_encoder #(
    parameter int MAX_SYMS   = 6,
    parameter int CNT_W      = 16,
    parameter int DEB_TICKS  = 2,
    parameter int DOT_MIN    = 2,
    parameter int DASH_MIN   = 6,
    parameter int LETTER_GAP = 6,
    parameter int WORD_GAP   = 14
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   tick,
    input  logic                   button,
    morse_keyer_encoder_if.master  kb
);
    localparam int LW = 2 * MAX_SYMS;
    localparam int SW = $clog2(MAX_SYMS + 1);
    localparam int DW = $clog2(DEB_TICKS + 1);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] DOT_C    = CNT_W'(DOT_MIN);
    localparam logic [CNT_W-1:0] DASH_C   = CNT_W'(DASH_MIN);
    localparam logic [CNT_W-1:0] LETTER_C = CNT_W'(LETTER_GAP);
    localparam logic [CNT_W-1:0] WORD_C   = CNT_W'(WORD_GAP);
    localparam logic [SW-1:0]    MAX_C    = SW'(MAX_SYMS);
    localparam logic [DW-1:0]    DEB_LAST = DW'(DEB_TICKS - 1);

    typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;

    logic          sync1, sync2;
    logic          btn_db;
    logic [DW-1:0] deb_cnt;
    logic          db_flip, db_rise;

    state_t        state, state_n;
    logic [CNT_W-1:0] press_cnt, press_n, press_inc;
    logic [CNT_W-1:0] gap_cnt, gap_n, gap_inc;
    logic [LW-1:0] acc, acc_n;
    logic [SW-1:0] acc_cnt, acc_cnt_n;
    logic          ovf, ovf_n;
    logic          dash;
    logic [1:0]    sym;

    logic [LW-1:0] letter_q, letter_n;
    logic [SW-1:0] cnt_q, cnt_n;
    logic          err_q, err_n;
    logic [1:0]    dod_q, dod_n;
    logic          let_v_q, let_v_n;
    logic          dod_v_q, dod_v_n;
    logic          word_q, word_n;

    // The level flips on the tick that completes a run of disagreeing samples.
    assign db_flip = tick && (sync2 != btn_db) && (deb_cnt == DEB_LAST);
    assign db_rise = db_flip && !btn_db;

    assign press_inc = (press_cnt == CNT_MAX) ? press_cnt : press_cnt + 1'b1;
    assign gap_inc   = (gap_cnt == CNT_MAX) ? gap_cnt : gap_cnt + 1'b1;
    assign dash      = (press_cnt >= DASH_C);
    assign sym       = dash ? 2'b11 : 2'b01;

    // Two-flop synchroniser and tick-based debounce of the raw key.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            btn_db  <= 1'b0;
            deb_cnt <= '0;
        end else begin
            sync1 <= button;
            sync2 <= sync1;
            if (db_flip) begin
                btn_db  <= ~btn_db;
                deb_cnt <= '0;
            end else if (tick) begin
                deb_cnt <= (sync2 != btn_db) ? deb_cnt + 1'b1 : '0;
            end
        end
    end

    // State, counters, accumulator and held outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            press_cnt <= '0;
            gap_cnt   <= '0;
            acc       <= '0;
            acc_cnt   <= '0;
            ovf       <= 1'b0;
            letter_q  <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            dod_q     <= 2'b00;
            let_v_q   <= 1'b0;
            dod_v_q   <= 1'b0;
            word_q    <= 1'b0;
        end else begin
            state     <= state_n;
            press_cnt <= press_n;
            gap_cnt   <= gap_n;
            acc       <= acc_n;
            acc_cnt   <= acc_cnt_n;
            ovf       <= ovf_n;
            letter_q  <= letter_n;
            cnt_q     <= cnt_n;
            err_q     <= err_n;
            dod_q     <= dod_n;
            let_v_q   <= let_v_n;
            dod_v_q   <= dod_v_n;
            word_q    <= word_n;
        end
    end

    // Next-state: counting, classification on release, letter/word close.
    always_comb begin
        state_n   = state;
        press_n   = press_cnt;
        gap_n     = gap_cnt;
        acc_n     = acc;
        acc_cnt_n = acc_cnt;
        ovf_n     = ovf;
        letter_n  = letter_q;
        cnt_n     = cnt_q;
        err_n     = err_q;
        dod_n     = dod_q;
        let_v_n   = 1'b0;
        dod_v_n   = 1'b0;
        word_n    = 1'b0;
        unique case (state)
            IDLE: begin
                if (db_rise) begin
                    state_n = PRESS;
                    press_n = '0;
                end
            end
            PRESS: begin
                if (btn_db) begin
                    if (tick) press_n = press_inc;
                end else begin
                    gap_n = '0;
                    if (press_cnt >= DOT_C) begin
                        dod_v_n = 1'b1;
                        dod_n   = dash ? 2'b10 : 2'b01;
                        state_n = GAP;
                        if (acc_cnt < MAX_C) begin
                            acc_n     = (acc << 2) | LW'(sym);
                            acc_cnt_n = acc_cnt + 1'b1;
                        end else begin
                            ovf_n = 1'b1;
                        end
                    end else begin
                        state_n = (acc_cnt != '0) ? GAP : IDLE;
                    end
                    if (db_rise) begin
                        state_n = PRESS;
                        press_n = '0;
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    gap_n = gap_inc;
                    if (gap_inc == LETTER_C && acc_cnt != '0) begin
                        let_v_n   = 1'b1;
                        letter_n  = acc;
                        cnt_n     = acc_cnt;
                        err_n     = ovf;
                        acc_n     = '0;
                        acc_cnt_n = '0;
                        ovf_n     = 1'b0;
                    end
                    if (gap_inc == WORD_C) begin
                        word_n  = 1'b1;
                        state_n = IDLE;
                    end
                end
                if (db_rise) begin
                    state_n = PRESS;
                    press_n = '0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign kb.letter       = letter_q;
    assign kb.sym_count    = cnt_q;
    assign kb.letter_err   = err_q;
    assign kb.letter_valid = let_v_q;
    assign kb.dod          = dod_q;
    assign kb.dod_valid    = dod_v_q;
    assign kb.word_gap     = word_q;
endmodule

// File: tb/tb_morse_keyer_encoder.sv
// Directed bench for the Morse keyer with a symbol/letter-level
// scoreboard model and per-cycle output comparison.
module tb_morse_keyer_encoder;
    logic clk = 1'b0;
    logic reset;
    logic tick;
    logic button;

    morse_keyer_encoder_if #(.MAX_SYMS(6)) kif ();

    morse_keyer_encoder dut (
        .clk    (clk),
        .reset  (reset),
        .tick   (tick),
        .button (button),
        .kb     (kif)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int tick_per = 1;

    typedef struct packed {
        logic [11:0] l;
        logic [2:0]  c;
        logic        e;
    } let_t;

    logic [1:0] q_dod[$];
    let_t       q_let[$];
    int         q_word = 0;

    logic [1:0] m_syms[$];
    bit         m_ovf = 0;
    bit         m_gap = 0;

    logic [1:0]  h_dod = 0;
    let_t        h_let = '0;
    let_t        last_let = '0;
    logic [1:0]  last_dod = 0;
    int seen_dod = 0, seen_let = 0, seen_word = 0;
    int dod_cyc = 0, let_cyc = 0, word_cyc = 0, t_fall = 0;

    function automatic void chk(input string nm, input logic [31:0] act,
                                input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic void flag(input string nm);
        total++;
        bad++;
        $display("FAIL %s: got pulse expected none", nm);
    endfunction

    // Model: one completed press of n ticks
    function automatic void m_press(input int n);
        logic [1:0] s;
        if (n < 2) begin
            m_gap = (m_syms.size() > 0);
            return;
        end
        s = (n >= 6) ? 2'b11 : 2'b01;
        q_dod.push_back((n >= 6) ? 2'b10 : 2'b01);
        if (m_syms.size() < 6) m_syms.push_back(s);
        else m_ovf = 1;
        m_gap = 1;
    endfunction

    // Model: a silence of g ticks after a press
    function automatic void m_silence(input int g);
        let_t x;
        if (!m_gap) return;
        if (g >= 6 && m_syms.size() > 0) begin
            x.l = 0;
            foreach (m_syms[i]) x.l = {x.l[9:0], m_syms[i]};
            x.c = 3'(m_syms.size());
            x.e = m_ovf;
            q_let.push_back(x);
            m_syms.delete();
            m_ovf = 0;
        end
        if (g >= 14) begin
            q_word++;
            m_gap = 0;
        end
    endfunction

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input int n);
        m_press(n);
        button = 1'b1;
        clks(n * tick_per);
        button = 1'b0;
        t_fall = cyc;
    endtask

    task automatic silence(input int g);
        m_silence(g);
        clks(g * tick_per + 1);
    endtask

    task automatic drained(input string nm);
        clks(6);
        chk({nm, "_dod_left"}, q_dod.size(), 0);
        chk({nm, "_let_left"}, q_let.size(), 0);
        chk({nm, "_word_left"}, q_word, 0);
    endtask

    task automatic out_zero(input string nm);
        chk({nm, "_letter"}, kif.letter, 0);
        chk({nm, "_sym_count"}, kif.sym_count, 0);
        chk({nm, "_letter_err"}, kif.letter_err, 0);
        chk({nm, "_letter_valid"}, kif.letter_valid, 0);
        chk({nm, "_dod"}, kif.dod, 0);
        chk({nm, "_dod_valid"}, kif.dod_valid, 0);
        chk({nm, "_word_gap"}, kif.word_gap, 0);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Tick generator: one pulse every tick_per clocks
    initial begin
        int d;
        d = 0;
        tick = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            d = (d + 1 >= tick_per) ? 0 : d + 1;
            tick = (d == 0);
        end
    end

    // Compare process: scoreboard pops on pulses, hold checks otherwise
    initial begin
        let_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                h_dod = 0;
                h_let = '0;
            end else begin
                if (kif.dod_valid) begin
                    seen_dod++;
                    dod_cyc = cyc;
                    last_dod = kif.dod;
                    if (q_dod.size() == 0) flag("dod_unexpected");
                    else begin
                        h_dod = q_dod.pop_front();
                        chk("dod", kif.dod, h_dod);
                    end
                end else begin
                    chk("dod_hold", kif.dod, h_dod);
                end
                if (kif.letter_valid) begin
                    seen_let++;
                    let_cyc = cyc;
                    last_let = {kif.letter, kif.sym_count, kif.letter_err};
                    if (q_let.size() == 0) flag("letter_unexpected");
                    else begin
                        e = q_let.pop_front();
                        h_let = e;
                        chk("letter", kif.letter, e.l);
                        chk("sym_count", kif.sym_count, e.c);
                        chk("letter_err", kif.letter_err, e.e);
                    end
                end else begin
                    chk("letter_hold", kif.letter, h_let.l);
                    chk("sym_count_hold", kif.sym_count, h_let.c);
                    chk("letter_err_hold", kif.letter_err, h_let.e);
                end
                if (kif.word_gap) begin
                    seen_word++;
                    word_cyc = cyc;
                    if (q_word == 0) flag("word_gap_unexpected");
                    else q_word--;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sd, sl, sw;
        reset  = 1'b1;
        button = 1'b0;
        clks(3);
        out_zero("reset");
        reset = 1'b0;
        clks(3);

        // 1: dot then letter, with latency pinned
        sw = seen_word;
        press(3);
        sd = t_fall;
        silence(20);
        drained("s1");
        chk("s1_letter_lit", last_let.l, 12'h001);
        chk("s1_count_lit", last_let.c, 1);
        chk("s1_err_lit", last_let.e, 0);
        chk("s1_dod_lit", last_dod, 2'b01);
        chk("s1_dod_latency", dod_cyc - sd, 5);
        chk("s1_let_latency", let_cyc - sd, 11);
        chk("s1_words", seen_word - sw, 1);

        // 2: dash at exact threshold, shortest dot, word gap
        press(6);
        silence(2);
        press(2);
        silence(20);
        drained("s2");
        chk("s2_letter_lit", last_let.l, 12'h00D);
        chk("s2_count_lit", last_let.c, 2);
        chk("s2_word_after_letter", word_cyc - let_cyc, 8);

        // Letter gap boundary: 5 keeps the letter open
        press(3);
        silence(5);
        press(6);
        silence(20);
        drained("lgap");
        chk("lgap_letter_lit", last_let.l, 12'h007);

        // Press between letter and word gap: two letters, one word
        sl = seen_let;
        sw = seen_word;
        press(3);
        silence(13);
        press(3);
        silence(20);
        drained("wgap");
        chk("wgap_letters", seen_let - sl, 2);
        chk("wgap_words", seen_word - sw, 1);

        // 3: single-clock bounces never reach the debounced level
        sd = seen_dod;
        sl = seen_let;
        for (int i = 0; i < 6; i++) begin
            button = 1'b1;
            clks(1);
            button = 1'b0;
            clks(1 + (i % 3));
        end
        drained("bounce");
        chk("bounce_dods", seen_dod - sd, 0);
        chk("bounce_letters", seen_let - sl, 0);

        // 4: overflow, then a clean letter
        sd = seen_dod;
        for (int i = 0; i < 7; i++) begin
            press(3);
            silence(i == 6 ? 20 : 2);
        end
        drained("ovf");
        chk("ovf_dods", seen_dod - sd, 7);
        chk("ovf_letter_lit", last_let.l, 12'h555);
        chk("ovf_count_lit", last_let.c, 6);
        chk("ovf_err_lit", last_let.e, 1);
        press(6);
        silence(20);
        drained("post_ovf");
        chk("post_ovf_err_lit", last_let.e, 0);
        chk("post_ovf_letter_lit", last_let.l, 12'h003);

        // 5: reset mid-press discards the partial letter
        press(3);
        silence(2);
        press(3);
        silence(2);
        button = 1'b1;
        clks(3);
        reset = 1'b1;
        clks(1);
        button = 1'b0;
        clks(2);
        out_zero("midreset");
        chk("midreset_dod_left", q_dod.size(), 0);
        m_syms.delete();
        m_ovf = 0;
        m_gap = 0;
        reset = 1'b0;
        clks(5);
        press(6);
        silence(20);
        drained("s5");
        chk("s5_letter_lit", last_let.l, 12'h003);
        chk("s5_count_lit", last_let.c, 1);

        // 6: slow time base, 3 ticks over 12 clocks is a dot
        tick_per = 4;
        clks(8);
        press(3);
        silence(20);
        drained("slow");
        chk("slow_dod_lit", last_dod, 2'b01);
        chk("slow_letter_lit", last_let.l, 12'h001);
        tick_per = 1;
        clks(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/morse_keyer_encoder.md
Name: morse_keyer_encoder

Overview:
- Parametrised successor to the single-button dot/dash encoder: a debounced, tick-timed Morse keyer front end.
- Classifies each press as dot or dash against programmable thresholds and accumulates up to MAX_SYMS symbols per letter.
- Closes a letter on an inter-letter silence and flags word boundaries on a longer silence.
- Sits between the board push-button and the Morse-to-ASCII lookup and display logic.

Parameters:
- MAX_SYMS, 6: maximum symbols per letter; the letter bus is 2*MAX_SYMS bits.
- CNT_W, 16: width of the press and gap tick counters; both saturate at 2^CNT_W-1.
- DEB_TICKS, 2: consecutive ticks a synchronised sample must disagree before the debounced level flips.
- DOT_MIN, 2: minimum press ticks for a dot; shorter presses are glitches.
- DASH_MIN, 6: minimum press ticks for a dash.
- LETTER_GAP, 6: release ticks that close a letter.
- WORD_GAP, 14: release ticks that flag a word boundary.
- Legal set: 1<=DOT_MIN<DASH_MIN; LETTER_GAP<WORD_GAP; all values <2^CNT_W.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- tick  in  1  time-base enable, one clk wide; all timing counts ticks.
- button  in  1  raw, asynchronous key input.
- letter  out  2*MAX_SYMS  completed letter: 2 bits per symbol, LSBs are the latest symbol; 01=dot, 11=dash, 00=empty.
- sym_count  out  $clog2(MAX_SYMS+1)  number of symbols in letter.
- letter_valid  out  1  one-cycle pulse; letter, sym_count and letter_err are valid.
- letter_err  out  1  letter overflowed and at least one symbol was dropped.
- dod  out  2  last symbol: 01=dot, 10=dash.
- dod_valid  out  1  one-cycle pulse with a new dod.
- word_gap  out  1  one-cycle pulse at a word boundary.

Behaviour:
- Reset: all outputs, counters, the accumulator, the sync flops and the debounced level go to 0; state goes to IDLE. Reset mid-press or mid-gap discards the partial letter and emits no pulse.
- Input conditioning: button passes through a 2-flop synchroniser (every clk). On each tick where the synchronised value differs from btn_db, a debounce counter increments, otherwise it clears. When it reaches DEB_TICKS, btn_db toggles and the counter clears.
- States: IDLE, PRESS, GAP.
- IDLE: on btn_db 0->1, go to PRESS with press_cnt=0.
- PRESS: on every tick with btn_db=1, press_cnt increments (saturating). On btn_db 1->0, classify on the next clk edge:
  - press_cnt<DOT_MIN: glitch. No symbol and no pulse. Go to GAP (gap_cnt=0) if acc_cnt>0, else IDLE.
  - DOT_MIN<=press_cnt<DASH_MIN: dot. dod=01, dod_valid=1.
  - press_cnt>=DASH_MIN: dash. dod=10, dod_valid=1. Exactly DASH_MIN is a dash; no dead zone.
- Accumulating a symbol: if acc_cnt<MAX_SYMS, shift acc left 2 and append the symbol code, acc_cnt+1. Otherwise drop the symbol and set sticky ovf; dod_valid still pulses. Go to GAP with gap_cnt=0.
- GAP: on every tick with btn_db=0, gap_cnt increments (saturating).
  - btn_db 0->1 before LETTER_GAP: go to PRESS; accumulation continues.
  - gap_cnt reaches LETTER_GAP with acc_cnt>0: for one cycle, letter=acc, sym_count=acc_cnt, letter_err=ovf, letter_valid=1. Then clear acc, acc_cnt and ovf, and stay in GAP.
  - gap_cnt reaches WORD_GAP: word_gap=1 for one cycle, go to IDLE. A press between LETTER_GAP and WORD_GAP goes to PRESS and emits no word_gap.
- Output holding: letter, sym_count and letter_err hold their last emitted values until the next letter_valid. dod holds until the next dod_valid.
- Simultaneous events: a tick on the same cycle as a btn_db edge is counted in the old state. Classification and letter close never coincide, because letter close needs LETTER_GAP>=1 released ticks.
- Latency:
  - dod_valid: 1 clk after the btn_db fall.
  - letter_valid: on the clk edge after the tick on which gap_cnt reaches LETTER_GAP.
  - A raw button edge reaches btn_db after 2 clk of synchronisation plus DEB_TICKS ticks.

Test Plan:
All scenarios use default parameters and tick=1 every clk. Press and gap lengths are counted in debounced ticks.
1. Press 3, release 6: dod=01 pulse, then letter_valid with letter=0x001, sym_count=1, letter_err=0.
2. Press 6 (boundary), gap 2, press 2, gap 14: dash then dot. letter=0x00D, sym_count=2, then word_gap 8 ticks later, state IDLE.
3. Press 1 only: no dod_valid, letter_valid or word_gap; state returns to IDLE. Also: raw 1-tick bounce pulses shorter than DEB_TICKS never move btn_db.
4. Seven dots at gap 2, then gap 6: dod_valid x7; letter=0x555, sym_count=6, letter_err=1. The next letter has letter_err=0.
5. Reset asserted mid-press after 2 dots: all outputs 0; the following dash yields letter=0x003, sym_count=1.
6. Tick every 4th clk, press 3 ticks (12 clk): classified as dot, confirming timing counts ticks and not clk.
